// File: rtl/wb_cmd_master.sv
// Wishbone initiator: turns single-word commands from a valid/ready port into classic Wishbone
// cycles, with one transaction outstanding and an ACK timeout against dead or unmapped slaves.
module wb_cmd_master #(
  parameter int unsigned          ADDRWIDTH      = 10,
  parameter int unsigned          DATAWIDTH      = 32,
  parameter int unsigned          TIMEOUT_CYCLES = 255,
  parameter logic [DATAWIDTH-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [ADDRWIDTH-1:0] cmd_adr_i,
  input  logic [DATAWIDTH-1:0] cmd_dat_i,
  input  logic [3:0]           cmd_be_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATAWIDTH-1:0] rsp_dat_o,
  output logic                 rsp_err_o,
  output logic                 busy_o,
  output logic [7:0]           timeout_cnt_o,
  output logic [ADDRWIDTH-1:0] WBm_ADR_o,
  output logic                 WBm_CYC_o,
  output logic                 WBm_STB_o,
  output logic                 WBm_WE_o,
  output logic [3:0]           WBm_BYTE_STB_o,
  output logic [DATAWIDTH-1:0] WBm_DAT_o,
  input  logic [DATAWIDTH-1:0] WBm_DAT_i,
  input  logic                 WBm_ACK_i
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  // Count value on the edge where CYC has been high for TIMEOUT_CYCLES cycles.
  localparam logic [15:0] TimeoutLast =
      (TIMEOUT_CYCLES == 0) ? 16'd0 : 16'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [ADDRWIDTH-1:0]   adr_q, adr_d;
  logic                   cyc_q, cyc_d;
  logic                   we_q, we_d;
  logic [3:0]             be_q, be_d;
  logic [DATAWIDTH-1:0]   dat_q, dat_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATAWIDTH-1:0]   rsp_dat_q, rsp_dat_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [7:0]             tocnt_q, tocnt_d;

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state_q     <= StIdle;
      adr_q       <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= '0;
      dat_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      tocnt_q     <= '0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      be_q        <= be_d;
      dat_q       <= dat_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      tocnt_q     <= tocnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    be_d        = be_q;
    dat_d       = dat_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    tocnt_d     = tocnt_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          adr_d   = {cmd_adr_i[ADDRWIDTH-1:2], 2'b00};
          we_d    = cmd_we_i;
          be_d    = cmd_be_i;
          dat_d   = cmd_dat_i;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = StBus;
        end
      end
      StBus: begin
        // ACK is checked first so it wins over a timeout on the same edge.
        if (WBm_ACK_i) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_dat_d   = we_q ? '0 : WBm_DAT_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (cnt_q == TimeoutLast) begin
            cyc_d       = 1'b0;
            we_d        = 1'b0;
            rsp_dat_d   = TIMEOUT_DATA;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            if (tocnt_q != 8'hFF) tocnt_d = tocnt_q + 8'd1;
            state_d     = StResp;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign cmd_ready_o    = (state_q == StIdle) && !WBs_RST_i;
  assign busy_o         = (state_q != StIdle);
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_dat_o      = rsp_dat_q;
  assign rsp_err_o      = rsp_err_q;
  assign timeout_cnt_o  = tocnt_q;
  assign WBm_ADR_o      = adr_q;
  assign WBm_CYC_o      = cyc_q;
  assign WBm_STB_o      = cyc_q;
  assign WBm_WE_o       = we_q;
  assign WBm_BYTE_STB_o = be_q;
  assign WBm_DAT_o      = dat_q;

endmodule
